// File: rtl/surfturf_wb_watchdog.sv
// -----------------------------------------------------------------------------
// surfturf_wb_watchdog
//
// Registered Wishbone bridge that sits directly upstream of the SURF/TURF
// interface wrapper's target port. One upstream access is forwarded at a
// time. If the addressed sub-slave never answers (for example an unclocked
// link), the access is abandoned after TIMEOUT_CYCLES strobe cycles so the
// upstream master always terminates. Timeouts are counted and the address of
// the most recent timed-out access is kept for debug.
//
// Ports
//   wb_clk_i, wb_rst_i      : clock and synchronous active-high reset
//   wb_cyc_i .. wb_we_i     : upstream Wishbone request (from the master)
//   wb_ack_o, wb_err_o      : upstream termination (single-cycle pulses)
//   wb_rty_o                : upstream retry, never used (constant 0)
//   wb_dat_o                : upstream read data
//   m_wb_cyc_o .. m_wb_we_o : downstream request (to the wrapper)
//   m_wb_ack_i/err_i/rty_i  : downstream termination
//   m_wb_dat_i              : downstream read data
//   timeout_count_o         : saturating count of timed-out accesses
//   timeout_adr_o           : address of the most recent timed-out access
// -----------------------------------------------------------------------------
module surfturf_wb_watchdog #(
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter int                    ERR_ON_TIMEOUT = 0,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(32'hBADC0DE5)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  // upstream target side
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  // downstream master side
  output logic                    m_wb_cyc_o,
  output logic                    m_wb_stb_o,
  output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
  output logic                    m_wb_we_o,
  input  logic                    m_wb_ack_i,
  input  logic                    m_wb_err_i,
  input  logic                    m_wb_rty_i,
  input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
  // debug
  output logic [15:0]             timeout_count_o,
  output logic [ADDR_WIDTH-1:0]   timeout_adr_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter value seen on the last strobe cycle before the access is dropped.
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state_reg,    state_next;
  logic [15:0]               cnt_reg,      cnt_next;
  logic                      ack_reg,      ack_next;
  logic                      err_reg,      err_next;
  logic [DATA_WIDTH-1:0]     rdat_reg,     rdat_next;
  logic                      m_cyc_reg,    m_cyc_next;
  logic                      m_stb_reg,    m_stb_next;
  logic [ADDR_WIDTH-1:0]     m_adr_reg,    m_adr_next;
  logic [DATA_WIDTH-1:0]     m_dat_reg,    m_dat_next;
  logic [DATA_WIDTH/8-1:0]   m_sel_reg,    m_sel_next;
  logic                      m_we_reg,     m_we_next;
  logic [15:0]               timeout_count_reg, timeout_count_next;
  logic [ADDR_WIDTH-1:0]     timeout_adr_reg,   timeout_adr_next;

  // State and output registers. Every register is reloaded each cycle from
  // its _next value, so nothing holds implicitly outside the comb block.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      ack_reg           <= 1'b0;
      err_reg           <= 1'b0;
      rdat_reg          <= '0;
      m_cyc_reg         <= 1'b0;
      m_stb_reg         <= 1'b0;
      m_adr_reg         <= '0;
      m_dat_reg         <= '0;
      m_sel_reg         <= '0;
      m_we_reg          <= 1'b0;
      timeout_count_reg <= '0;
      timeout_adr_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      ack_reg           <= ack_next;
      err_reg           <= err_next;
      rdat_reg          <= rdat_next;
      m_cyc_reg         <= m_cyc_next;
      m_stb_reg         <= m_stb_next;
      m_adr_reg         <= m_adr_next;
      m_dat_reg         <= m_dat_next;
      m_sel_reg         <= m_sel_next;
      m_we_reg          <= m_we_next;
      timeout_count_reg <= timeout_count_next;
      timeout_adr_reg   <= timeout_adr_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    ack_next           = 1'b0;   // terminations are single-cycle pulses
    err_next           = 1'b0;
    rdat_next          = rdat_reg;
    m_cyc_next         = m_cyc_reg;
    m_stb_next         = m_stb_reg;
    m_adr_next         = m_adr_reg;
    m_dat_next         = m_dat_reg;
    m_sel_next         = m_sel_reg;
    m_we_next          = m_we_reg;
    timeout_count_next = timeout_count_reg;
    timeout_adr_next   = timeout_adr_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          m_adr_next = wb_adr_i;
          m_dat_next = wb_dat_i;
          m_sel_next = wb_sel_i;
          m_we_next  = wb_we_i;
          m_cyc_next = 1'b1;
          m_stb_next = 1'b1;
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_next = cnt_reg + 16'd1;
        // Priority: abort, ack, err/rty, timeout. A real answer arriving on
        // the expiry cycle therefore beats the timeout.
        if (!wb_cyc_i) begin
          m_cyc_next = 1'b0;
          m_stb_next = 1'b0;
          state_next = ST_IDLE;
        end else if (m_wb_ack_i) begin
          m_cyc_next = 1'b0;
          m_stb_next = 1'b0;
          ack_next   = 1'b1;
          rdat_next  = m_wb_dat_i;
          state_next = ST_DONE;
        end else if (m_wb_err_i || m_wb_rty_i) begin
          m_cyc_next = 1'b0;
          m_stb_next = 1'b0;
          err_next   = 1'b1;
          rdat_next  = '0;
          state_next = ST_DONE;
        end else if (cnt_reg == LAST_COUNT) begin
          m_cyc_next = 1'b0;
          m_stb_next = 1'b0;
          if (ERR_ON_TIMEOUT != 0) begin
            err_next  = 1'b1;
            rdat_next = '0;
          end else begin
            ack_next  = 1'b1;
            rdat_next = TIMEOUT_DATA;
          end
          timeout_adr_next = m_adr_reg;
          if (timeout_count_reg != 16'hFFFF) begin
            timeout_count_next = timeout_count_reg + 16'd1;
          end
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // Upstream request lines are deliberately ignored here so a strobe
        // still held by the master is not issued a second time.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign wb_ack_o        = ack_reg;
  assign wb_err_o        = err_reg;
  assign wb_rty_o        = 1'b0;
  assign wb_dat_o        = rdat_reg;
  assign m_wb_cyc_o      = m_cyc_reg;
  assign m_wb_stb_o      = m_stb_reg;
  assign m_wb_adr_o      = m_adr_reg;
  assign m_wb_dat_o      = m_dat_reg;
  assign m_wb_sel_o      = m_sel_reg;
  assign m_wb_we_o       = m_we_reg;
  assign timeout_count_o = timeout_count_reg;
  assign timeout_adr_o   = timeout_adr_reg;

endmodule

// File: tb/tb_surfturf_wb_watchdog.sv
// -----------------------------------------------------------------------------
// tb_surfturf_wb_watchdog
//
// Two bridges (timeout terminates with ack / with err) see identical stimulus.
// A transaction-level reference model predicts every output after each clock
// edge; directed scenarios add checks against fixed constants, then a long
// randomized run exercises aborts, errors, retries, dead slaves and resets.
// -----------------------------------------------------------------------------
module tb_surfturf_wb_watchdog;

  localparam int TO = 16;
  localparam logic [31:0] TO_DATA = 32'hBADC0DE5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic        rst = 1'b1;
  logic        u_cyc = 1'b0, u_stb = 1'b0, u_we = 1'b0;
  logic [11:0] u_adr = '0;
  logic [31:0] u_dat = '0;
  logic [3:0]  u_sel = '0;
  logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [31:0] s_dat = '0;

  // DUT outputs, index 0: timeout -> ack, index 1: timeout -> err
  logic        ack_o [2];
  logic        err_o [2];
  logic        rty_o [2];
  logic [31:0] dat_o [2];
  logic        mcyc_o [2];
  logic        mstb_o [2];
  logic [11:0] madr_o [2];
  logic [31:0] mdat_o [2];
  logic [3:0]  msel_o [2];
  logic        mwe_o [2];
  logic [15:0] tcnt_o [2];
  logic [11:0] tadr_o [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    surfturf_wb_watchdog #(
      .ADDR_WIDTH     (12),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TO),
      .ERR_ON_TIMEOUT (gi),
      .TIMEOUT_DATA   (TO_DATA)
    ) u_dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .wb_cyc_i        (u_cyc),
      .wb_stb_i        (u_stb),
      .wb_adr_i        (u_adr),
      .wb_dat_i        (u_dat),
      .wb_sel_i        (u_sel),
      .wb_we_i         (u_we),
      .wb_ack_o        (ack_o[gi]),
      .wb_err_o        (err_o[gi]),
      .wb_rty_o        (rty_o[gi]),
      .wb_dat_o        (dat_o[gi]),
      .m_wb_cyc_o      (mcyc_o[gi]),
      .m_wb_stb_o      (mstb_o[gi]),
      .m_wb_adr_o      (madr_o[gi]),
      .m_wb_dat_o      (mdat_o[gi]),
      .m_wb_sel_o      (msel_o[gi]),
      .m_wb_we_o       (mwe_o[gi]),
      .m_wb_ack_i      (s_ack),
      .m_wb_err_i      (s_err),
      .m_wb_rty_i      (s_rty),
      .m_wb_dat_i      (s_dat),
      .timeout_count_o (tcnt_o[gi]),
      .timeout_adr_o   (tadr_o[gi])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a bridge is either idle, carrying one outstanding access
  // (whose strobe has been visible for 'age' cycles), or in its one-cycle
  // termination window.
  // ---------------------------------------------------------------------------
  bit          m_busy [2] = '{0, 0};
  bit          m_term [2] = '{0, 0};
  int          m_age  [2] = '{0, 0};
  logic        e_ack  [2] = '{0, 0};
  logic        e_err  [2] = '{0, 0};
  logic [31:0] e_dat  [2] = '{0, 0};
  logic        e_mcyc [2] = '{0, 0};
  logic [11:0] e_madr [2] = '{0, 0};
  logic [31:0] e_mdat [2] = '{0, 0};
  logic [3:0]  e_msel [2] = '{0, 0};
  logic        e_mwe  [2] = '{0, 0};
  logic [15:0] e_tcnt [2] = '{0, 0};
  logic [11:0] e_tadr [2] = '{0, 0};

  task automatic finish_access(input int k, input bit is_ack, input logic [31:0] d);
    m_busy[k] = 0;
    m_term[k] = 1;
    e_mcyc[k] = 0;
    e_ack[k]  = is_ack;
    e_err[k]  = !is_ack;
    e_dat[k]  = d;
  endtask

  task automatic predict(input int k);
    if (rst) begin
      m_busy[k] = 0; m_term[k] = 0; m_age[k] = 0;
      e_ack[k] = 0; e_err[k] = 0; e_dat[k] = 0; e_mcyc[k] = 0;
      e_madr[k] = 0; e_mdat[k] = 0; e_msel[k] = 0; e_mwe[k] = 0;
      e_tcnt[k] = 0; e_tadr[k] = 0;
    end else if (m_term[k]) begin
      m_term[k] = 0;
      e_ack[k]  = 0;
      e_err[k]  = 0;
    end else if (!m_busy[k]) begin
      if (u_cyc && u_stb) begin
        m_busy[k] = 1;
        m_age[k]  = 0;
        e_mcyc[k] = 1;
        e_madr[k] = u_adr; e_mdat[k] = u_dat; e_msel[k] = u_sel; e_mwe[k] = u_we;
      end
    end else begin
      m_age[k]++;                       // strobe cycles seen at this edge
      if (!u_cyc) begin
        m_busy[k] = 0;
        e_mcyc[k] = 0;
      end else if (s_ack) begin
        finish_access(k, 1, s_dat);
      end else if (s_err || s_rty) begin
        finish_access(k, 0, 32'h0);
      end else if (m_age[k] == TO) begin
        if (k == 1) finish_access(k, 0, 32'h0);
        else        finish_access(k, 1, TO_DATA);
        e_tadr[k] = e_madr[k];
        if (e_tcnt[k] != 16'hFFFF) e_tcnt[k] = e_tcnt[k] + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("i%0d.ack", k),  ack_o[k],  e_ack[k]);
      check_val($sformatf("i%0d.err", k),  err_o[k],  e_err[k]);
      check_val($sformatf("i%0d.rty", k),  rty_o[k],  1'b0);
      check_val($sformatf("i%0d.dat", k),  dat_o[k],  e_dat[k]);
      check_val($sformatf("i%0d.mcyc", k), mcyc_o[k], e_mcyc[k]);
      check_val($sformatf("i%0d.mstb", k), mstb_o[k], e_mcyc[k]);
      check_val($sformatf("i%0d.madr", k), madr_o[k], e_madr[k]);
      check_val($sformatf("i%0d.mdat", k), mdat_o[k], e_mdat[k]);
      check_val($sformatf("i%0d.msel", k), msel_o[k], e_msel[k]);
      check_val($sformatf("i%0d.mwe", k),  mwe_o[k],  e_mwe[k]);
      check_val($sformatf("i%0d.tcnt", k), tcnt_o[k], e_tcnt[k]);
      check_val($sformatf("i%0d.tadr", k), tadr_o[k], e_tadr[k]);
    end
  endtask

  // One clock: predict from the inputs now applied, let the edge happen,
  // then compare on the falling edge. Callers change inputs between ticks.
  task automatic tick();
    predict(0);
    predict(1);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    u_cyc = 0; u_stb = 0; s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  task automatic issue(input logic [11:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    u_cyc = 1; u_stb = 1; u_adr = adr; u_dat = dat; u_sel = sel; u_we = we;
    tick();
  endtask

  // Dead-slave access: returns how many cycles the downstream strobe was up.
  task automatic run_timeout(input logic [11:0] adr, output int n);
    issue(adr, 32'hCAFEF00D, 4'hF, 1'b1);
    n = 0;
    while (mstb_o[0] === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n, n_stb, n_ack;

    // reset
    tick();
    check_val("reset.mcyc", mcyc_o[0], 1'b0);
    check_val("reset.tcnt", tcnt_o[0], 16'h0);
    rst = 0;
    tick();

    // read, slave answers 3 cycles after the strobe appears
    issue(12'h010, 32'h0, 4'hF, 1'b0);
    check_val("rd.stb_latency", mstb_o[0], 1'b1);
    tick();
    tick();
    s_ack = 1; s_dat = 32'h12345678;
    tick();
    check_val("rd.ack", ack_o[0], 1'b1);
    check_val("rd.dat", dat_o[0], 32'h12345678);
    s_ack = 0; u_cyc = 0; u_stb = 0;
    tick();
    check_val("rd.ack_pulse", ack_o[0], 1'b0);
    check_val("rd.tcnt", tcnt_o[0], 16'h0);

    // write to a dead slave
    run_timeout(12'h0C4, n);
    check_val("to.stb_cycles", n, TO);
    check_val("to.ack0", ack_o[0], 1'b1);
    check_val("to.dat0", dat_o[0], TO_DATA);
    check_val("to.err1", err_o[1], 1'b1);
    check_val("to.ack1", ack_o[1], 1'b0);
    check_val("to.tcnt", tcnt_o[0], 16'h1);
    check_val("to.tadr", tadr_o[0], 12'h0C4);
    check_val("to.mdat", mdat_o[0], 32'hCAFEF00D);
    idle_inputs();
    tick();

    // ack coincident with the last timeout cycle
    issue(12'h123, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    s_ack = 1; s_dat = 32'hA5A50F0F;
    tick();
    check_val("race.ack0", ack_o[0], 1'b1);
    check_val("race.dat0", dat_o[0], 32'hA5A50F0F);
    check_val("race.err1", err_o[1], 1'b0);
    check_val("race.tcnt", tcnt_o[1], 16'h1);
    idle_inputs();
    tick();

    // upstream abort 4 cycles into the access, then a late ack
    issue(12'h222, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    u_cyc = 0; u_stb = 0;
    tick();
    check_val("abort.mcyc", mcyc_o[0], 1'b0);
    check_val("abort.ack", ack_o[0], 1'b0);
    s_ack = 1;
    tick();
    check_val("abort.late_ack", ack_o[0], 1'b0);
    check_val("abort.tcnt", tcnt_o[0], 16'h1);
    idle_inputs();
    tick();

    // back-to-back with zero-wait slave, strobe held throughout
    u_cyc = 1; u_stb = 1; n_stb = 0; n_ack = 0;
    for (int i = 0; i < 30; i++) begin
      s_ack = mstb_o[0];
      s_dat = $urandom;
      tick();
      if (mstb_o[0] === 1'b1) n_stb++;
      if (ack_o[0] === 1'b1)  n_ack++;
    end
    check_val("b2b.strobes", n_stb, 10);
    check_val("b2b.acks", n_ack, 10);
    idle_inputs();
    tick();

    // reset during an outstanding access
    issue(12'h333, 32'h0, 4'hF, 1'b0);
    rst = 1;
    tick();
    check_val("rst_mid.mcyc", mcyc_o[0], 1'b0);
    check_val("rst_mid.ack", ack_o[0], 1'b0);
    check_val("rst_mid.tcnt", tcnt_o[0], 16'h0);
    rst = 0;
    idle_inputs();
    tick();

    // saturation of the timeout counter
    force g_dut[0].u_dut.timeout_count_reg = 16'hFFFE;
    force g_dut[1].u_dut.timeout_count_reg = 16'hFFFE;
    e_tcnt[0] = 16'hFFFE;
    e_tcnt[1] = 16'hFFFE;
    tick();
    release g_dut[0].u_dut.timeout_count_reg;
    release g_dut[1].u_dut.timeout_count_reg;
    for (int t = 0; t < 3; t++) begin
      run_timeout(12'h400 + 12'(t), n);
      idle_inputs();
      tick();
      check_val("sat.tcnt0", tcnt_o[0], 16'hFFFF);
      check_val("sat.tcnt1", tcnt_o[1], 16'hFFFF);
    end

    // randomized traffic
    begin
      bit dead = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 99) == 0) dead = !dead;
        rst   = ($urandom_range(0, 399) == 0);
        u_cyc = ($urandom_range(0, 19) != 0);
        u_stb = u_cyc && ($urandom_range(0, 3) != 0);
        u_adr = 12'($urandom);
        u_dat = $urandom;
        u_sel = 4'($urandom);
        u_we  = 1'($urandom);
        s_ack = !dead && ($urandom_range(0, 5) == 0);
        s_err = !dead && ($urandom_range(0, 23) == 0);
        s_rty = !dead && ($urandom_range(0, 23) == 0);
        s_dat = $urandom;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
